bag_queue: RTL and testbench

Parametrised 7-bag piece generator with a lookahead queue. It supersedes the single-bag `bag` block. It draws pieces from an LFSR without replacement until every piece type has been issued, then starts a new bag automatically. Drawn pieces are buffered in a FIFO whose head feeds the game controller through a valid/ready handshake and whose following entries drive the "next pieces" preview on the display.

---
 rtl/bag_pkg.sv | 31 +++
 rtl/bag_queue_lfsr.sv | 23 ++
 rtl/bag_queue.sv | 134 +++++++++++++
 tb/tb_bag_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bag_pkg.sv
// Shared types, defaults and helpers for the 7-bag piece generator.
package bag_pkg;

    localparam int DEF_NUM_PIECES = 7;
    localparam int DEF_PIECE_W    = 3;

    typedef logic [DEF_PIECE_W-1:0] piece_t;

    // Galois (right-shift) feedback masks for maximal-length polynomials
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            8:       return 32'h0000_00B8;
            12:      return 32'h0000_0E08;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return (32'h1 << (width - 1)) | 32'h1;
        endcase
    endfunction

    function automatic int lowest_unset(input logic [31:0] flags, input int n);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (i < n && !flags[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bag_queue_lfsr.sv
// Galois LFSR; reset and load both take load_value, otherwise it steps every cycle.
module lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            state <= load_value;
        end else if (state[0]) begin
            state <= (state >> 1) ^ TAPS;
        end else begin
            state <= state >> 1;
        end
    end

endmodule

// File: rtl/bag_queue.sv
// 7-bag piece generator feeding a shift-register FIFO with parallel preview taps.
module bag_queue
    import bag_pkg::*;
#(
    parameter int                NUM_PIECES = DEF_NUM_PIECES,
    parameter int                PIECE_W    = DEF_PIECE_W,
    parameter int                PREVIEW    = 5,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                MAX_TRIES  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode_random,
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed,
    input  logic                          newbag,
    input  logic                          piece_ready,
    output logic                          piece_valid,
    output logic [PIECE_W-1:0]            piece,
    output logic [PREVIEW*PIECE_W-1:0]    preview,
    output logic [$clog2(PREVIEW+2)-1:0]  preview_count,
    output logic [NUM_PIECES-1:0]         bag_flags,
    output logic                          bag_done
);

    localparam int DEPTH = PREVIEW + 1;
    localparam int CNT_W = $clog2(PREVIEW + 2);
    localparam int TRY_W = $clog2(MAX_TRIES + 2);
    localparam logic [TRY_W-1:0]      TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [NUM_PIECES-1:0] ALL_SET   = '1;

    logic [LFSR_W-1:0]     lfsr_state;
    logic [LFSR_W-1:0]     lfsr_load_value;
    logic                  unused_lfsr_bits;
    logic [PIECE_W-1:0]    q  [DEPTH];
    logic [PIECE_W-1:0]    nq [DEPTH];
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      ncnt;
    logic [TRY_W-1:0]      tries;
    logic                  pop;
    logic                  attempt;
    logic                  accept;
    logic [PIECE_W-1:0]    cand;
    logic [PIECE_W-1:0]    lowest;
    logic [PIECE_W-1:0]    pick;
    logic [NUM_PIECES-1:0] nflags;

    // Reset reuses the load path; a zero seed would lock the LFSR, so SEED stands in
    assign lfsr_load_value = (reset || seed == '0) ? SEED : seed;

    lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_W'(lfsr_taps(LFSR_W)))
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (seed_load),
        .load_value (lfsr_load_value),
        .state      (lfsr_state)
    );

    assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:PIECE_W];
    assign cand    = lfsr_state[PIECE_W-1:0];
    assign lowest  = PIECE_W'(lowest_unset(32'(bag_flags), NUM_PIECES));
    assign pop     = piece_valid && piece_ready;
    assign attempt = (cnt < CNT_W'(DEPTH)) || pop;
    assign nflags  = bag_flags | (NUM_PIECES'(1) << pick);

    always_comb begin
        accept = 1'b0;
        pick   = lowest;
        if (attempt) begin
            if (!mode_random || tries >= TRY_LIMIT) begin
                accept = 1'b1;
            end else if (int'(cand) < NUM_PIECES && !bag_flags[cand]) begin
                accept = 1'b1;
                pick   = cand;
            end
        end
    end

    // Pop shifts toward the head first, so a simultaneous push lands at the new tail
    always_comb begin
        nq   = q;
        ncnt = cnt;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) nq[i] = q[i+1];
            nq[DEPTH-1] = '0;
            ncnt = cnt - CNT_W'(1);
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ncnt == CNT_W'(i)) nq[i] = pick;
            end
            ncnt = ncnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || newbag) begin
            cnt       <= '0;
            tries     <= '0;
            bag_flags <= '0;
            bag_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            q        <= nq;
            cnt      <= ncnt;
            bag_done <= 1'b0;
            if (accept) begin
                tries <= '0;
                if (nflags == ALL_SET) begin
                    bag_flags <= '0;
                    bag_done  <= 1'b1;
                end else begin
                    bag_flags <= nflags;
                end
            end else if (attempt) begin
                tries <= tries + TRY_W'(1);
            end
        end
    end

    assign piece_valid   = (cnt != '0);
    assign piece         = q[0];
    assign preview_count = piece_valid ? cnt - CNT_W'(1) : '0;

    always_comb begin
        preview = '0;
        for (int k = 0; k < PREVIEW; k++) preview[k*PIECE_W +: PIECE_W] = q[k+1];
    end

endmodule

// File: tb/tb_bag_queue.sv
// Directed bench for bag_queue: deterministic fill/drain, random bags, fallback, flush, seed and reset.
module tb_bag_queue;
    import bag_pkg::*;

    localparam int MT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mode_random, seed_load, newbag, piece_ready;
    logic [15:0] seed;
    logic        piece_valid;
    piece_t      piece;
    logic [14:0] preview;
    logic [2:0]  preview_count;
    logic [6:0]  bag_flags;
    logic        bag_done;

    logic        mode2, seed_load2, newbag2, ready2;
    logic [15:0] seed2;
    logic        valid2;
    piece_t      piece2;
    logic [14:0] preview2;
    logic [2:0]  count2;
    logic [6:0]  flags2;
    logic        done2;

    int checks   = 0;
    int failures = 0;

    bag_queue dut (
        .clk(clk), .reset(reset), .mode_random(mode_random), .seed_load(seed_load),
        .seed(seed), .newbag(newbag), .piece_ready(piece_ready),
        .piece_valid(piece_valid), .piece(piece), .preview(preview),
        .preview_count(preview_count), .bag_flags(bag_flags), .bag_done(bag_done)
    );

    bag_queue #(.MAX_TRIES(0)) dut_fb (
        .clk(clk), .reset(reset), .mode_random(mode2), .seed_load(seed_load2),
        .seed(seed2), .newbag(newbag2), .piece_ready(ready2),
        .piece_valid(valid2), .piece(piece2), .preview(preview2),
        .preview_count(count2), .bag_flags(flags2), .bag_done(done2)
    );

    // Hand-derived fill from SEED=ACE1 in random mode: queue 1,0,4,6,3,2, piece 5 still undrawn
    localparam logic [14:0] SEED_PREVIEW = {3'd2, 3'd3, 3'd6, 3'd4, 3'd0};
    localparam logic [14:0] DET_PREVIEW  = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

    task automatic test_reset();
        reset = 1'b1; mode_random = 1'b0; seed_load = 1'b0; seed = '0;
        newbag = 1'b0; piece_ready = 1'b0;
        mode2 = 1'b1; seed_load2 = 1'b0; seed2 = '0; newbag2 = 1'b0; ready2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (piece_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", piece_valid); end
        checks++; if (piece !== 3'd0) begin failures++; $display("FAIL reset_piece got=%0d want=0", piece); end
        checks++; if (preview !== 15'd0) begin failures++; $display("FAIL reset_preview got=%h want=0", preview); end
        checks++; if (preview_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", preview_count); end
        checks++; if (bag_flags !== 7'd0) begin failures++; $display("FAIL reset_flags got=%b want=0", bag_flags); end
        checks++; if (bag_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bag_done); end
    endtask

    task automatic test_det_fill();
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (piece_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b want=1", piece_valid); end
        checks++; if (piece !== 3'd0) begin failures++; $display("FAIL fill_piece got=%0d want=0", piece); end
        checks++; if (preview !== DET_PREVIEW) begin failures++; $display("FAIL fill_preview got=%h want=%h", preview, DET_PREVIEW); end
        checks++; if (preview_count !== 3'd5) begin failures++; $display("FAIL fill_count got=%0d want=5", preview_count); end
        checks++; if (bag_flags !== 7'b0111111) begin failures++; $display("FAIL fill_flags got=%b want=0111111", bag_flags); end
    endtask

    task automatic test_det_drain();
        piece_ready = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            checks++; if (piece !== 3'(i % 7)) begin failures++; $display("FAIL drain_piece[%0d] got=%0d want=%0d", i, piece, i % 7); end
            checks++; if (piece_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b want=1", i, piece_valid); end
            checks++; if (bag_done !== (i % 7 == 1)) begin failures++; $display("FAIL drain_done[%0d] got=%b want=%b", i, bag_done, (i % 7 == 1)); end
        end
        piece_ready = 1'b0;
    endtask

    task automatic test_fallback();
        ready2 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (valid2 !== 1'b1 || piece2 !== 3'(i % 7)) begin
                failures++; $display("FAIL fallback_seq[%0d] got=%0d valid=%b want=%0d", i, piece2, valid2, i % 7);
            end
            @(negedge clk);
        end
        ready2 = 1'b0;
    endtask

    task automatic test_flush();
        newbag = 1'b1;
        @(negedge clk);
        newbag = 1'b0;
        repeat (10) @(negedge clk);
        piece_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (piece !== 3'd3) begin failures++; $display("FAIL flush_pre_piece got=%0d want=3", piece); end
        newbag = 1'b1;
        @(negedge clk);
        newbag = 1'b0; piece_ready = 1'b0;
        checks++; if (piece_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", piece_valid); end
        checks++; if (bag_flags !== 7'd0) begin failures++; $display("FAIL flush_flags got=%b want=0", bag_flags); end
        checks++; if (bag_done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b want=0", bag_done); end
        checks++; if (preview_count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d want=0", preview_count); end
        @(negedge clk);
        checks++; if (piece_valid !== 1'b1 || piece !== 3'd0) begin failures++; $display("FAIL flush_refill got=%0d valid=%b want=0 valid=1", piece, piece_valid); end
        checks++; if (bag_flags !== 7'b0000001) begin failures++; $display("FAIL flush_refill_flags got=%b want=0000001", bag_flags); end
    endtask

    task automatic test_random_perm();
        int         pops;
        int         cyc;
        int         gap;
        int         max_gap;
        int         grp;
        logic [6:0] mask;
        logic       dup;
        pops = 0; cyc = 0; gap = 0; max_gap = 0; grp = 0; mask = '0; dup = 1'b0;
        mode_random = 1'b1; newbag = 1'b1; seed_load = 1'b1; seed = 16'h1234;
        @(negedge clk);
        newbag = 1'b0; seed_load = 1'b0; piece_ready = 1'b1;
        while (pops < 700 && cyc < 20000) begin
            if (piece_valid) begin
                if (piece > 3'd6) dup = 1'b1;
                else begin
                    if (mask[piece]) dup = 1'b1;
                    mask[piece] = 1'b1;
                end
                pops++;
                gap = 0;
                if (pops % 7 == 0) begin
                    checks++;
                    if (dup || mask !== 7'h7F) begin
                        failures++; $display("FAIL perm_group[%0d] got=%b dup=%b want=1111111", grp, mask, dup);
                    end
                    grp++; mask = '0; dup = 1'b0;
                end
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            @(negedge clk);
            cyc++;
        end
        piece_ready = 1'b0;
        checks++; if (pops != 700) begin failures++; $display("FAIL perm_timeout got=%0d pops want=700", pops); end
        checks++; if (max_gap > MT + 1) begin failures++; $display("FAIL perm_latency got=%0d want<=%0d", max_gap, MT + 1); end
    endtask

    task automatic test_seed_zero();
        mode_random = 1'b1; newbag = 1'b1; seed_load = 1'b1; seed = 16'h0000;
        @(negedge clk);
        newbag = 1'b0; seed_load = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (piece_valid !== 1'b1 || piece !== 3'd1) begin failures++; $display("FAIL seed0_piece got=%0d valid=%b want=1", piece, piece_valid); end
        checks++; if (preview !== SEED_PREVIEW) begin failures++; $display("FAIL seed0_preview got=%h want=%h", preview, SEED_PREVIEW); end
        checks++; if (preview_count !== 3'd5) begin failures++; $display("FAIL seed0_count got=%0d want=5", preview_count); end
        checks++; if (bag_flags !== 7'h5F) begin failures++; $display("FAIL seed0_flags got=%b want=1011111", bag_flags); end
    endtask

    task automatic test_reset_edge();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (piece_valid !== 1'b0 || piece !== 3'd0) begin failures++; $display("FAIL rst_full_head got=%0d valid=%b want=0", piece, piece_valid); end
        checks++; if (preview !== 15'd0 || preview_count !== 3'd0) begin failures++; $display("FAIL rst_full_preview got=%h cnt=%0d want=0", preview, preview_count); end
        checks++; if (bag_flags !== 7'd0 || bag_done !== 1'b0) begin failures++; $display("FAIL rst_full_flags got=%b done=%b want=0", bag_flags, bag_done); end
        checks++; if (valid2 !== 1'b0) begin failures++; $display("FAIL rst_full_fb got=%b want=0", valid2); end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (piece !== 3'd1 || preview !== SEED_PREVIEW) begin failures++; $display("FAIL rst_resume got=%0d/%h want=1/%h", piece, preview, SEED_PREVIEW); end
        checks++; if (bag_flags !== 7'h5F) begin failures++; $display("FAIL rst_resume_flags got=%b want=1011111", bag_flags); end
    endtask

    initial begin
        test_reset();
        test_det_fill();
        test_det_drain();
        test_fallback();
        test_flush();
        test_random_perm();
        test_seed_zero();
        test_reset_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
